// File: rtl/fifo_wr_arb.sv
// Two-requester write arbiter in front of a FIFO write port.
// Round-robin grant, whole-frame ownership, burst cap only under contention.
module fifo_wr_arb #(
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_rst,
  input  logic [DATA_WIDTH-1:0] req0_data,
  input  logic                  req0_valid,
  input  logic                  req0_last,
  output logic                  req0_ready,
  input  logic [DATA_WIDTH-1:0] req1_data,
  input  logic                  req1_valid,
  input  logic                  req1_last,
  output logic                  req1_ready,
  input  logic                  wr_full,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_inc,
  output logic [1:0]            grant
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BMAX = CW'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic [CW-1:0] beat_q, beat_d;

  logic          own0, own1;
  logic          cur_valid, cur_last, oth_valid;
  logic          wr_en;
  logic [CW-1:0] beat_nx;

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  always_comb begin
    cur_valid = 1'b0;
    cur_last  = 1'b0;
    oth_valid = 1'b0;
    unique case (1'b1)
      own0: begin
        cur_valid = req0_valid;
        cur_last  = req0_last;
        oth_valid = req1_valid;
      end
      own1: begin
        cur_valid = req1_valid;
        cur_last  = req1_last;
        oth_valid = req0_valid;
      end
      default: ;
    endcase
  end

  assign wr_en = cur_valid & ~wr_full;

  // Counter saturates so a lone requester can stream past the cap.
  always_comb begin
    beat_nx = beat_q;
    if (wr_en && (beat_q != BMAX)) begin
      beat_nx = beat_q + CW'(1);
    end
  end

  always_ff @(posedge wr_clk or negedge wr_rst) begin
    if (!wr_rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    beat_d  = beat_q;
    unique case (state_q)
      IDLE: begin
        if (req0_valid && (!req1_valid || last_q)) begin
          state_d = OWN0;
          last_d  = 1'b0;
          beat_d  = '0;
        end else if (req1_valid) begin
          state_d = OWN1;
          last_d  = 1'b1;
          beat_d  = '0;
        end
      end
      OWN0, OWN1: begin
        beat_d = beat_nx;
        if ((wr_en && cur_last) ||
            ((beat_nx == BMAX) && oth_valid)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    wr_inc     = 1'b0;
    wr_data    = '0;
    unique case (state_q)
      OWN0: begin
        req0_ready = ~wr_full;
        wr_inc     = req0_valid & ~wr_full;
        wr_data    = req0_data;
      end
      OWN1: begin
        req1_ready = ~wr_full;
        wr_inc     = req1_valid & ~wr_full;
        wr_data    = req1_data;
      end
      default: ;
    endcase
  end

  assign grant = {own1, own0};

endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: requester drivers, write scoreboard,
// and per-cycle grant/strobe/ready expectations.
module tb_fifo_wr_arb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req0_data, req1_data;
  logic       req0_valid, req0_last, req0_ready;
  logic       req1_valid, req1_last, req1_ready;
  logic       wr_full;
  logic [7:0] wr_data;
  logic       wr_inc;
  logic [1:0] grant;

  int total = 0;
  int bad   = 0;

  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [9:0] exq[$];
  logic       hold0 = 1'b0;

  always #5 clk = ~clk;

  fifo_wr_arb #(.DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .wr_clk     (clk),
    .wr_rst     (rst_n),
    .req0_data  (req0_data),
    .req0_valid (req0_valid),
    .req0_last  (req0_last),
    .req0_ready (req0_ready),
    .req1_data  (req1_data),
    .req1_valid (req1_valid),
    .req1_last  (req1_last),
    .req1_ready (req1_ready),
    .wr_full    (wr_full),
    .wr_data    (wr_data),
    .wr_inc     (wr_inc),
    .grant      (grant)
  );

  initial begin
    logic a0;
    req0_valid = 1'b0;
    req0_last  = 1'b0;
    req0_data  = '0;
    forever begin
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      @(posedge clk);
      #2;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (q0.size() > 0 && !hold0) begin
        req0_valid = 1'b1;
        {req0_last, req0_data} = q0[0];
      end else begin
        req0_valid = 1'b0;
        req0_last  = 1'b0;
        req0_data  = '0;
      end
    end
  end

  initial begin
    logic a1;
    req1_valid = 1'b0;
    req1_last  = 1'b0;
    req1_data  = '0;
    forever begin
      @(negedge clk);
      a1 = req1_valid && req1_ready;
      @(posedge clk);
      #2;
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      if (q1.size() > 0) begin
        req1_valid = 1'b1;
        {req1_last, req1_data} = q1[0];
      end else begin
        req1_valid = 1'b0;
        req1_last  = 1'b0;
        req1_data  = '0;
      end
    end
  end

  always @(negedge clk) begin
    logic [9:0] e;
    if (wr_inc === 1'b1) begin
      total++;
      if (exq.size() == 0) begin
        bad++;
        $display("FAIL sb_extra act grant=%b data=%h req none",
                 grant, wr_data);
      end else begin
        e = exq.pop_front();
        if ({grant, wr_data} !== e) begin
          bad++;
          $display("FAIL sb_word act grant=%b data=%h req grant=%b data=%h",
                   grant, wr_data, e[9:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h req=%0h", nm, act, exp);
    end
  endtask

  task automatic cyc(input string nm, input logic f, input logic h,
                     input logic [1:0] g, input logic inc);
    logic [4:0] ex;
    @(posedge clk);
    #1;
    wr_full = f;
    hold0   = h;
    @(negedge clk);
    ex = {g, inc, (g == 2'b01) && !f, (g == 2'b10) && !f};
    chk(nm, 32'({grant, wr_inc, req0_ready, req1_ready}), 32'(ex));
    if (g == 2'b00) chk({nm, "_data"}, 32'(wr_data), 32'd0);
  endtask

  task automatic run_seq(input string nm, input string g, input string i,
                         input string f, input string h);
    for (int k = 0; k < g.len(); k++) begin
      logic [7:0] bg, bi, bf, bh;
      bg = g[k];
      bi = i[k];
      bf = f[k];
      bh = h[k];
      cyc($sformatf("%s_c%0d", nm, k), bf[0], bh[0], bg[1:0], bi[0]);
    end
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    wr_full = 1'b0;
    hold0   = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("rst_async", 32'({grant, wr_inc, req0_ready, req1_ready}), 32'd0);
    chk("rst_data", 32'(wr_data), 32'd0);
    run_seq("rst", "00", "00", "00", "00");
    rst_n = 1'b1;
    run_seq("rst_rel", "0", "0", "0", "0");
  endtask

  task automatic ld(input int r, input logic [7:0] d, input logic l);
    if (r == 0) q0.push_back({l, d});
    else        q1.push_back({l, d});
  endtask

  task automatic ex(input logic [1:0] g, input logic [7:0] d);
    exq.push_back({g, d});
  endtask

  initial begin
    rst_n   = 1'b0;
    wr_full = 1'b0;
    do_reset();

    // single 3-word frame from req0
    ld(0, 8'hA1, 0); ld(0, 8'hA2, 0); ld(0, 8'hA3, 1);
    ex(2'b01, 8'hA1); ex(2'b01, 8'hA2); ex(2'b01, 8'hA3);
    run_seq("frame0", "01110", "01110", "00000", "00000");

    // contention from reset: bursts of 4 alternate
    do_reset();
    for (int n = 0; n < 8; n++) begin
      ld(0, 8'h30 + 8'(n), n == 7);
      ld(1, 8'hB0 + 8'(n), n == 7);
    end
    for (int n = 0; n < 4; n++) ex(2'b01, 8'h30 + 8'(n));
    for (int n = 0; n < 4; n++) ex(2'b10, 8'hB0 + 8'(n));
    for (int n = 4; n < 8; n++) ex(2'b01, 8'h30 + 8'(n));
    for (int n = 4; n < 8; n++) ex(2'b10, 8'hB0 + 8'(n));
    run_seq("alt", "011110222201111022220", "011110111101111011110",
            "000000000000000000000", "000000000000000000000");

    // lone req1 streams past the burst cap
    for (int n = 0; n < 6; n++) begin
      ld(1, 8'hC0 + 8'(n), n == 5);
      ex(2'b10, 8'hC0 + 8'(n));
    end
    run_seq("solo1", "02222220", "01111110", "00000000", "00000000");

    // FIFO full for 3 cycles mid-frame
    for (int n = 0; n < 6; n++) begin
      ld(0, 8'hD0 + 8'(n), n == 5);
      ex(2'b01, 8'hD0 + 8'(n));
    end
    run_seq("full", "01111111110", "01100011110", "00011100000",
            "00000000000");

    // req0 stalls 2 cycles while req1 waits
    for (int n = 0; n < 6; n++) ld(0, 8'hE0 + 8'(n), n == 5);
    for (int n = 0; n < 4; n++) ex(2'b01, 8'hE0 + 8'(n));
    ex(2'b10, 8'hF0); ex(2'b10, 8'hF1);
    ex(2'b01, 8'hE4); ex(2'b01, 8'hE5);
    run_seq("stall_a", "011", "011", "000", "000");
    ld(1, 8'hF0, 0); ld(1, 8'hF1, 1);
    run_seq("stall_b", "11110220110", "00110110110", "00000000000",
            "11000000000");

    // async reset while req1 owns mid-frame
    for (int n = 0; n < 6; n++) ld(1, 8'h60 + 8'(n), n == 5);
    ex(2'b10, 8'h60); ex(2'b10, 8'h61);
    run_seq("own1", "022", "011", "000", "000");
    #1;
    do_reset();
    ld(0, 8'h70, 0); ld(0, 8'h71, 1); ld(1, 8'h80, 1);
    ex(2'b01, 8'h70); ex(2'b01, 8'h71); ex(2'b10, 8'h80);
    run_seq("tie", "011020", "011010", "000000", "000000");

    chk("sb_drain", 32'(exq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
